// File: rtl/player_shot_controller.sv
// Player shot controller: debounced buttons drive a grid cursor and a
// validated shot handed to the game FSM over valid/ready.
module player_shot_controller #(
  parameter int ROWS            = 12,
  parameter int COLS            = 12,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic       player_turn,
  input  logic       new_game,
  input  logic       shot_ready,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       shot_valid,
  output logic [3:0] shot_row,
  output logic [3:0] shot_col,
  output logic       repeat_err,
  output logic       aiming
);

  localparam int NB    = 5;
  localparam int B_UP  = 0;
  localparam int B_DN  = 1;
  localparam int B_LT  = 2;
  localparam int B_RT  = 3;
  localparam int B_FR  = 4;
  localparam int CW    = (DEBOUNCE_CYCLES > 2) ?
                         $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CELLS = ROWS * COLS;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    ROW_MAX = 4'(ROWS - 1);
  localparam logic [3:0]    COL_MAX = 4'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    AIM,
    PENDING
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;
  logic [NB-1:0] deb_d;
  logic [NB-1:0] press;
  logic [CW-1:0] cnt [NB];

  logic [CELLS-1:0] fired;
  logic [IW-1:0]    cur_idx;
  logic [IW-1:0]    shot_idx;

  logic [3:0] row_nxt;
  logic [3:0] col_nxt;
  logic       latch_shot;
  logic       accept;
  logic       rep_nxt;

  assign raw = {btn_fire, btn_right, btn_left,
                btn_down, btn_up};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Level flips only after CNT_MAX+1 consecutive disagreeing cycles.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
      deb   <= '0;
      deb_d <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_MAX) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  assign cur_idx  = IW'(cursor_row * COLS + cursor_col);
  assign shot_idx = IW'(shot_row * COLS + shot_col);

  always_comb begin
    row_nxt = cursor_row;
    case ({press[B_UP], press[B_DN]})
      2'b10: row_nxt = (cursor_row == 4'd0) ?
                       ROW_MAX : cursor_row - 4'd1;
      2'b01: row_nxt = (cursor_row == ROW_MAX) ?
                       4'd0 : cursor_row + 4'd1;
      default: row_nxt = cursor_row;
    endcase
  end

  always_comb begin
    col_nxt = cursor_col;
    case ({press[B_LT], press[B_RT]})
      2'b10: col_nxt = (cursor_col == 4'd0) ?
                       COL_MAX : cursor_col - 4'd1;
      2'b01: col_nxt = (cursor_col == COL_MAX) ?
                       4'd0 : cursor_col + 4'd1;
      default: col_nxt = cursor_col;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    latch_shot = 1'b0;
    accept     = 1'b0;
    rep_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (player_turn) begin
          state_nxt = AIM;
        end
      end
      AIM: begin
        if (!player_turn) begin
          state_nxt = IDLE;
        end else if (press[B_FR]) begin
          if (fired[cur_idx]) begin
            rep_nxt = 1'b1;
          end else begin
            latch_shot = 1'b1;
            state_nxt  = PENDING;
          end
        end
      end
      PENDING: begin
        if (shot_ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new match drops any in-flight shot.
    if (new_game) begin
      state_nxt  = IDLE;
      latch_shot = 1'b0;
      accept     = 1'b0;
      rep_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cursor_row <= '0;
      cursor_col <= '0;
    end else if (new_game) begin
      cursor_row <= '0;
      cursor_col <= '0;
    end else if (state != PENDING) begin
      cursor_row <= row_nxt;
      cursor_col <= col_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shot_row <= '0;
      shot_col <= '0;
    end else if (latch_shot) begin
      shot_row <= cursor_row;
      shot_col <= cursor_col;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fired <= '0;
    end else if (new_game) begin
      fired <= '0;
    end else if (accept) begin
      fired[shot_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      repeat_err <= 1'b0;
    end else begin
      repeat_err <= rep_nxt;
    end
  end

  assign shot_valid = (state == PENDING);
  assign aiming     = (state == AIM);

endmodule

// File: tb/tb_player_shot_controller.sv
// Directed bench for player_shot_controller with a 4-cycle
// debounce window.
module tb_player_shot_controller;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_fire;
  logic       player_turn;
  logic       new_game;
  logic       shot_ready;
  logic [3:0] cursor_row;
  logic [3:0] cursor_col;
  logic       shot_valid;
  logic [3:0] shot_row;
  logic [3:0] shot_col;
  logic       repeat_err;
  logic       aiming;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  player_shot_controller #(
    .ROWS(12),
    .COLS(12),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_fire(btn_fire),
    .player_turn(player_turn),
    .new_game(new_game),
    .shot_ready(shot_ready),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .shot_valid(shot_valid),
    .shot_row(shot_row),
    .shot_col(shot_col),
    .repeat_err(repeat_err),
    .aiming(aiming)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic press(input logic u, input logic d,
                       input logic l, input logic r,
                       input logic f);
    {btn_up, btn_down, btn_left, btn_right, btn_fire} =
      {u, d, l, r, f};
    cyc(8);
    {btn_up, btn_down, btn_left, btn_right, btn_fire} = '0;
    cyc(8);
  endtask

  task automatic fire_count(output int rc, output int sc);
    rc = 0;
    sc = 0;
    btn_fire = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) btn_fire = 1'b0;
      cyc(1);
      if (repeat_err) rc++;
      if (shot_valid) sc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(2);
    tests++;
    if (cursor_row !== 4'd0 || cursor_col !== 4'd0) begin
      fails++;
      $display("FAIL reset_cursor: got %0d,%0d want 0,0",
               cursor_row, cursor_col);
    end
    tests++;
    if (shot_valid !== 1'b0 || repeat_err !== 1'b0 ||
        aiming !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got v%b e%b a%b want 000",
               shot_valid, repeat_err, aiming);
    end
    tests++;
    if (shot_row !== 4'd0 || shot_col !== 4'd0) begin
      fails++;
      $display("FAIL reset_shot: got %0d,%0d want 0,0",
               shot_row, shot_col);
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_debounce;
    int early;
    btn_down = 1'b1;
    cyc(3);
    btn_down = 1'b0;
    cyc(10);
    tests++;
    if (cursor_row !== 4'd0) begin
      fails++;
      $display("FAIL glitch_row: got %0d want 0", cursor_row);
    end
    early = 0;
    btn_down = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      if (cursor_row !== 4'd0) early++;
    end
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL debounce_early: got %0d moves want 0",
               early);
    end
    cyc(1);
    tests++;
    if (cursor_row !== 4'd1) begin
      fails++;
      $display("FAIL debounce_edge7: got %0d want 1",
               cursor_row);
    end
    cyc(3);
    btn_down = 1'b0;
    cyc(10);
    tests++;
    if (cursor_row !== 4'd1) begin
      fails++;
      $display("FAIL debounce_once: got %0d want 1",
               cursor_row);
    end
  endtask

  task automatic test_wrap;
    new_game = 1'b1;
    cyc(1);
    new_game = 1'b0;
    tests++;
    if (cursor_row !== 4'd0 || cursor_col !== 4'd0) begin
      fails++;
      $display("FAIL newgame_cursor: got %0d,%0d want 0,0",
               cursor_row, cursor_col);
    end
    press(1, 0, 0, 0, 0);
    tests++;
    if (cursor_row !== 4'd11) begin
      fails++;
      $display("FAIL wrap_up: got %0d want 11", cursor_row);
    end
    press(0, 0, 1, 0, 0);
    tests++;
    if (cursor_col !== 4'd11) begin
      fails++;
      $display("FAIL wrap_left: got %0d want 11", cursor_col);
    end
    press(0, 0, 0, 1, 0);
    tests++;
    if (cursor_col !== 4'd0) begin
      fails++;
      $display("FAIL wrap_right: got %0d want 0", cursor_col);
    end
    press(1, 1, 0, 0, 0);
    tests++;
    if (cursor_row !== 4'd11) begin
      fails++;
      $display("FAIL up_down: got %0d want 11", cursor_row);
    end
    press(0, 0, 1, 1, 0);
    tests++;
    if (cursor_col !== 4'd0) begin
      fails++;
      $display("FAIL left_right: got %0d want 0", cursor_col);
    end
    press(0, 1, 0, 1, 0);
    tests++;
    if (cursor_row !== 4'd0 || cursor_col !== 4'd1) begin
      fails++;
      $display("FAIL diag_wrap: got %0d,%0d want 0,1",
               cursor_row, cursor_col);
    end
  endtask

  task automatic test_shot;
    for (int k = 0; k < 3; k++) press(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) press(0, 0, 0, 1, 0);
    tests++;
    if (cursor_row !== 4'd3 || cursor_col !== 4'd5) begin
      fails++;
      $display("FAIL move_35: got %0d,%0d want 3,5",
               cursor_row, cursor_col);
    end
    player_turn = 1'b1;
    cyc(2);
    tests++;
    if (aiming !== 1'b1) begin
      fails++;
      $display("FAIL aim_on: got %b want 1", aiming);
    end
    press(0, 0, 0, 0, 1);
    tests++;
    if (shot_valid !== 1'b1 || shot_row !== 4'd3 ||
        shot_col !== 4'd5 || aiming !== 1'b0) begin
      fails++;
      $display("FAIL shot_35: got v%b %0d,%0d a%b want v1 3,5 a0",
               shot_valid, shot_row, shot_col, aiming);
    end
    press(0, 1, 0, 0, 0);
    tests++;
    if (shot_valid !== 1'b1 || shot_row !== 4'd3 ||
        shot_col !== 4'd5 || cursor_row !== 4'd3) begin
      fails++;
      $display("FAIL stall: got v%b %0d,%0d cur%0d want v1 3,5 cur3",
               shot_valid, shot_row, shot_col, cursor_row);
    end
    shot_ready = 1'b1;
    cyc(1);
    shot_ready = 1'b0;
    tests++;
    if (shot_valid !== 1'b0 || aiming !== 1'b0) begin
      fails++;
      $display("FAIL accept: got v%b a%b want v0 a0",
               shot_valid, aiming);
    end
    cyc(1);
    tests++;
    if (aiming !== 1'b1) begin
      fails++;
      $display("FAIL next_turn: got %b want 1", aiming);
    end
  endtask

  task automatic test_repeat;
    int rc;
    int sc;
    fire_count(rc, sc);
    tests++;
    if (rc !== 1 || sc !== 0) begin
      fails++;
      $display("FAIL repeat: got err%0d valid%0d want 1,0",
               rc, sc);
    end
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    tests++;
    if (shot_valid !== 1'b1 || shot_col !== 4'd6) begin
      fails++;
      $display("FAIL shot_36: got v%b col%0d want v1 col6",
               shot_valid, shot_col);
    end
    shot_ready = 1'b1;
    cyc(1);
    shot_ready = 1'b0;
    tests++;
    if (shot_valid !== 1'b0) begin
      fails++;
      $display("FAIL accept_36: got %b want 0", shot_valid);
    end
  endtask

  task automatic test_turn_gating;
    int rc;
    int sc;
    cyc(1);
    player_turn = 1'b0;
    cyc(2);
    tests++;
    if (aiming !== 1'b0) begin
      fails++;
      $display("FAIL turn_off: got %b want 0", aiming);
    end
    press(0, 0, 0, 1, 0);
    fire_count(rc, sc);
    tests++;
    if (sc !== 0 || rc !== 0 || cursor_col !== 4'd7) begin
      fails++;
      $display("FAIL idle_fire: got v%0d e%0d col%0d want 0,0,7",
               sc, rc, cursor_col);
    end
    player_turn = 1'b1;
    cyc(4);
    tests++;
    if (shot_valid !== 1'b0 || aiming !== 1'b1) begin
      fails++;
      $display("FAIL no_queue: got v%b a%b want v0 a1",
               shot_valid, aiming);
    end
  endtask

  task automatic test_new_game;
    int rc;
    int sc;
    press(0, 0, 0, 0, 1);
    tests++;
    if (shot_valid !== 1'b1 || shot_col !== 4'd7) begin
      fails++;
      $display("FAIL shot_37: got v%b col%0d want v1 col7",
               shot_valid, shot_col);
    end
    shot_ready = 1'b1;
    new_game   = 1'b1;
    cyc(1);
    shot_ready = 1'b0;
    new_game   = 1'b0;
    tests++;
    if (shot_valid !== 1'b0 || cursor_row !== 4'd0 ||
        cursor_col !== 4'd0 || aiming !== 1'b0) begin
      fails++;
      $display("FAIL ng_clear: got v%b %0d,%0d a%b want v0 0,0 a0",
               shot_valid, cursor_row, cursor_col, aiming);
    end
    for (int k = 0; k < 3; k++) press(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) press(0, 0, 0, 1, 0);
    fire_count(rc, sc);
    tests++;
    if (rc !== 0 || shot_valid !== 1'b1 ||
        shot_row !== 4'd3 || shot_col !== 4'd5) begin
      fails++;
      $display("FAIL ng_refire: got e%0d v%b %0d,%0d want e0 v1 3,5",
               rc, shot_valid, shot_row, shot_col);
    end
  endtask

  task automatic test_reset_mid;
    btn_down = 1'b1;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (cursor_row !== 4'd0 || cursor_col !== 4'd0 ||
        shot_valid !== 1'b0 || shot_row !== 4'd0 ||
        shot_col !== 4'd0 || repeat_err !== 1'b0 ||
        aiming !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got %0d,%0d v%b %0d,%0d e%b a%b",
               cursor_row, cursor_col, shot_valid, shot_row,
               shot_col, repeat_err, aiming);
    end
    btn_down = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    player_turn = 1'b0;
    cyc(10);
    tests++;
    if (cursor_row !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_row: got %0d want 0",
               cursor_row);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    btn_up      = 1'b0;
    btn_down    = 1'b0;
    btn_left    = 1'b0;
    btn_right   = 1'b0;
    btn_fire    = 1'b0;
    player_turn = 1'b0;
    new_game    = 1'b0;
    shot_ready  = 1'b0;
    test_reset();
    test_debounce();
    test_wrap();
    test_shot();
    test_repeat();
    test_turn_gating();
    test_new_game();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
